exec_unit_sliced: RTL and testbench
===================================

# exec_unit_sliced

Parametrised, multi-cycle successor to the 16-bit execution unit. It computes a WIDTH-bit ALU operation one SLICE-bit slice per cycle, rippling carry and zero state through registers between slices. It sits between the decode stage and writeback behind valid/ready handshakes. It adds correct inter-slice carry, full-width flags, backpressure and sequential control.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of SLICE.
- SLICE, 8: bits processed per cycle; NSLICE = WIDTH/SLICE, at least 1.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept; high only in IDLE.
- operanda, operandb  in  WIDTH  operands; sampled on accept.
- alu_op  in  3  opcode; sampled on accept.
- out_valid  out  1  result and flags valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- carry  out  1  final carry; for SUB/CMP, 1 means no borrow (A >= B unsigned).
- zero  out  1  result (or A-B for CMP) is all zeros.
- negative, overflow  out  1 each  present only with EXEC_EXT_FLAGS_EN.

## Operation
- Opcodes:
  - 000 PASS: result=A.
  - 001 ADD: A+B.
  - 010 SUB: A+~B+1.
  - 011 AND.
  - 100 OR.
  - 101 XOR.
  - 110 SHL: A<<1, shift-in 0, carry=A[WIDTH-1].
  - 111 CMP: computes A-B for flags only; result=A.
- All 8 codes are defined. Logic ops and PASS force carry=0.
- FSM states are IDLE, BUSY and DONE.
  - IDLE→BUSY on in_valid&&in_ready. Operands and opcode are latched, slice index idx=0, carry register = 1 for SUB/CMP, else 0. Zero accumulator = 1.
  - BUSY: each cycle processes slice idx (bits idx*SLICE+SLICE-1 : idx*SLICE). It writes the result slice, updates the carry register with the slice carry-out (or the slice MSB of A for SHL), ANDs in the slice's zero, and increments idx.
  - BUSY→DONE after slice NSLICE-1 completes.
  - DONE→IDLE on out_ready. Outputs stay stable while out_ready is low.
- Carry ripples only through the registered carry. No combinational path crosses slices.
- Wrap-around: sums modulo 2^WIDTH. Carry reports bit WIDTH.
- NSLICE=1: BUSY lasts exactly one cycle.
- Reset at any state: next edge goes to IDLE, and the in-flight op is discarded.
- Outputs in reset/IDLE: in_ready=1 after reset, out_valid=0, result=0, all flags 0.

## Timing
- Accept at edge T → BUSY during cycles T+1..T+NSLICE → out_valid high from cycle T+NSLICE+1.
- Latency is NSLICE+1 cycles from accept to out_valid.
- Minimum issue interval is NSLICE+2 cycles. No overlap between ops.
- in_ready is low from the accept edge until the cycle after the out_valid&&out_ready handshake.
- in_valid is ignored outside IDLE. Operand changes after accept have no effect.

## Configuration
- EXEC_EXT_FLAGS_EN defined:
  - negative = result[WIDTH-1], or (A-B)[WIDTH-1] for CMP.
  - overflow = signed overflow for ADD/SUB/CMP (carry into MSB XOR carry out of MSB, tracked in the last slice); 0 for other ops.
  - Both ports exist and reset to 0.
- Undefined: the ports and their logic are absent. All other behaviour is identical.

## Structure
- Package exec_pkg holds:
  - opcode localparams (OP_PASS..OP_CMP);
  - FSM state encoding (S_IDLE, S_BUSY, S_DONE);
  - the default SLICE value.
- Sub-module alu_slice is combinational and SLICE-parametrised. Inputs: a, b, op, cin. Outputs: y, cout, msb_cin, zero.
- The top level holds the FSM, idx counter, operand/result registers, carry register and flag accumulation.

## Test plan
All scenarios use WIDTH=16, SLICE=8.
- ADD 0x00FF+0x0001 → result 0x0100, carry 0, zero 0; out_valid exactly 3 cycles after accept (inter-slice carry check).
- ADD 0xFFFF+0x0001 → result 0x0000, carry 1, zero 1. SHL 0x8001 → 0x0002, carry 1.
- SUB 0x0001-0x0002 → 0xFFFF, carry 0. CMP 0x1234,0x1234 → result 0x1234, zero 1, carry 1.
- Backpressure: hold out_ready low 5 cycles after out_valid → result/flags stable, in_ready 0. Release → next op is accepted the cycle after the handshake.
- Assert rst during BUSY → next cycle in IDLE, out_valid 0, result 0, in_ready 1. A following ADD 3+4 → 7.
- With EXEC_EXT_FLAGS_EN: ADD 0x7FFF+0x0001 → 0x8000, overflow 1, negative 1. Re-run all scenarios with SLICE=16 and SLICE=4 for identical results and latency NSLICE+1.

Source files
------------

// File: rtl/exec_unit_sliced_pkg.sv
// ----------------------------------------------------------------------------
// exec_pkg
// Shared definitions for the sliced execution unit:
//   - ALU opcode encodings (OP_PASS .. OP_CMP)
//   - FSM state encoding (S_IDLE, S_BUSY, S_DONE)
//   - default slice width
// ----------------------------------------------------------------------------
package exec_pkg;

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_CMP  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam int DEFAULT_SLICE = 8;

  // SUB and CMP both run the adder on ~B with an initial carry of 1.
  function automatic logic is_subtract(input logic [2:0] op);
    return (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/exec_unit_sliced_alu_slice.sv
// ----------------------------------------------------------------------------
// alu_slice
// Purely combinational SLICE-bit ALU slice. The carry input comes from the
// registered carry of the previous slice, so no combinational path ever
// crosses a slice boundary.
// Ports:
//   a, b     in  SLICE  operand slices
//   op       in  3      opcode (exec_pkg OP_*)
//   cin      in  1      carry in (for SHL: the previous slice's MSB of A)
//   y        out SLICE  slice value (A-B for CMP; the top keeps A as result)
//   cout     out 1      carry out (A's slice MSB for SHL, 0 for logic/PASS)
//   msb_cin  out 1      carry into the slice MSB, used for signed overflow
//   zero     out 1      y is all zeros
// ----------------------------------------------------------------------------
module alu_slice
  import exec_pkg::*;
#(
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [SLICE-1:0] y,
  output logic             cout,
  output logic             msb_cin,
  output logic             zero
);

  logic [SLICE-1:0] bx;
  logic [SLICE:0]   sum;
  logic [SLICE:0]   shl;

  // Shared adder for ADD/SUB/CMP and the shift-with-carry-in vector
  always_comb begin
    if (is_subtract(op)) begin
      bx = ~b;
    end else begin
      bx = b;
    end
    sum = {1'b0, a} + {1'b0, bx} + {{SLICE{1'b0}}, cin};
    shl = {a, cin};
  end

  // Sum bit at the MSB equals a ^ b ^ carry-in, so the carry-in is recovered by XOR
  assign msb_cin = sum[SLICE-1] ^ a[SLICE-1] ^ bx[SLICE-1];

  // Opcode select for the slice value and carry out
  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_PASS: y = a;
      OP_ADD, OP_SUB, OP_CMP: begin
        y    = sum[SLICE-1:0];
        cout = sum[SLICE];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SHL: begin
        y    = shl[SLICE-1:0];
        cout = a[SLICE-1];
      end
      default: begin
        y    = a;
        cout = 1'b0;
      end
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/exec_unit_sliced.sv
// ----------------------------------------------------------------------------
// exec_unit_sliced
// Multi-cycle WIDTH-bit ALU that processes one SLICE-bit slice per cycle.
// Carry and zero state ripple between slices through registers only.
// WIDTH must be a multiple of SLICE; NSLICE = WIDTH/SLICE.
// Optional feature macro: EXEC_EXT_FLAGS_EN adds the negative/overflow ports.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operation handshake (in_ready high only in IDLE)
//   operanda, operandb   WIDTH-bit operands, alu_op 3-bit opcode
//   out_valid/out_ready  result handshake (out_valid high only in DONE)
//   result, carry, zero  result and flags, zero outside DONE
//   negative, overflow   extended flags (EXEC_EXT_FLAGS_EN only)
// ----------------------------------------------------------------------------
module exec_unit_sliced
  import exec_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operanda,
  input  logic [WIDTH-1:0] operandb,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
`ifdef EXEC_EXT_FLAGS_EN
  output logic             zero,
  output logic             negative,
  output logic             overflow
`else
  output logic             zero
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [2:0]       op;
  logic [IDXW-1:0]  idx;
  logic             cy;
  logic             zacc;
  logic             last;
  logic             is_arith;

  logic [SLICE-1:0] sl_a;
  logic [SLICE-1:0] sl_b;
  logic [SLICE-1:0] sl_y;
  logic [SLICE-1:0] sl_res;
  logic             sl_cout;
  logic             sl_msb_cin;
  logic             sl_zero;

  assign sl_a     = opa[int'(idx)*SLICE +: SLICE];
  assign sl_b     = opb[int'(idx)*SLICE +: SLICE];
  assign last     = (idx == LAST_IDX);
  assign is_arith = (op == OP_ADD) || is_subtract(op);
  // CMP only drives flags; the stored result stays A.
  assign sl_res   = (op == OP_CMP) ? sl_a : sl_y;

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a       (sl_a),
    .b       (sl_b),
    .op      (op),
    .cin     (cy),
    .y       (sl_y),
    .cout    (sl_cout),
    .msb_cin (sl_msb_cin),
    .zero    (sl_zero)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (in_valid) next_state = S_BUSY;
        else          next_state = S_IDLE;
      end
      S_BUSY: begin
        if (last) next_state = S_DONE;
        else      next_state = S_BUSY;
      end
      S_DONE: begin
        if (out_ready) next_state = S_IDLE;
        else           next_state = S_DONE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // FSM handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Accumulated result with the current slice merged in
  always_comb begin
    acc_next = acc;
    acc_next[int'(idx)*SLICE +: SLICE] = sl_res;
  end

  // Datapath: operand latch, per-slice ripple state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      opa      <= '0;
      opb      <= '0;
      op       <= OP_PASS;
      acc      <= '0;
      idx      <= '0;
      cy       <= 1'b0;
      zacc     <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
`ifdef EXEC_EXT_FLAGS_EN
      negative <= 1'b0;
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            opa  <= operanda;
            opb  <= operandb;
            op   <= alu_op;
            acc  <= '0;
            idx  <= '0;
            cy   <= is_subtract(alu_op);
            zacc <= 1'b1;
          end
        end
        S_BUSY: begin
          acc  <= acc_next;
          cy   <= sl_cout;
          zacc <= zacc & sl_zero;
          idx  <= idx + IDXW'(1);
          if (last) begin
            result   <= acc_next;
            carry    <= sl_cout;
            zero     <= zacc & sl_zero;
`ifdef EXEC_EXT_FLAGS_EN
            // sl_y is A-B for CMP, so the sign comes from the difference
            negative <= sl_y[SLICE-1];
            overflow <= is_arith & (sl_msb_cin ^ sl_cout);
`endif
          end
        end
        S_DONE: begin
          // Clearing on handshake keeps outputs at zero throughout IDLE
          if (out_ready) begin
            result   <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
`ifdef EXEC_EXT_FLAGS_EN
            negative <= 1'b0;
            overflow <= 1'b0;
`endif
          end
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_unit_sliced.sv
// ----------------------------------------------------------------------------
// tb_exec_unit_sliced
// Self-checking bench for exec_unit_sliced (WIDTH=16, SLICE parameter).
// Directed vector table, multi-cycle corner sequences (backpressure, reset in
// BUSY) and randomized operations against an arithmetic reference model.
// Honours EXEC_EXT_FLAGS_EN for the negative/overflow ports.
// ----------------------------------------------------------------------------
module tb_exec_unit_sliced;
  import exec_pkg::*;

  localparam int WIDTH  = 16;
  parameter  int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;

  typedef struct {
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    exp_t        e;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  operanda;
  logic [WIDTH-1:0]  operandb;
  logic [2:0]        alu_op;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  result;
  logic              carry;
  logic              zero;
`ifdef EXEC_EXT_FLAGS_EN
  logic              negative;
  logic              overflow;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_unit_sliced #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operanda  (operanda),
    .operandb  (operandb),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
`ifdef EXEC_EXT_FLAGS_EN
    .zero      (zero),
    .negative  (negative),
    .overflow  (overflow)
`else
    .zero      (zero)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole-word arithmetic straight from the opcode definitions
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    exp_t        e;
    logic [16:0] s;
    logic [15:0] diff;
    logic [15:0] fv;
    diff = a - b;
    e.v  = 1'b0;
    e.c  = 1'b0;
    case (op)
      OP_PASS: e.res = a;
      OP_ADD: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[15:0];
        e.c   = s[16];
        e.v   = (a[15] == b[15]) && (e.res[15] != a[15]);
      end
      OP_SUB, OP_CMP: begin
        e.res = (op == OP_CMP) ? a : diff;
        e.c   = (a >= b);
        e.v   = (a[15] != b[15]) && (diff[15] != a[15]);
      end
      OP_AND:  e.res = a & b;
      OP_OR:   e.res = a | b;
      OP_XOR:  e.res = a ^ b;
      OP_SHL: begin
        e.res = a << 1;
        e.c   = a[15];
      end
      default: e.res = a;
    endcase
    fv  = (op == OP_CMP) ? diff : e.res;
    e.z = (fv == 16'h0000);
    e.n = fv[15];
    return e;
  endfunction

  task automatic chk_idle(input string name);
    chk({name, " idle in_ready"}, in_ready, 1);
    chk({name, " idle out_valid"}, out_valid, 0);
    chk({name, " idle result"}, result, 0);
    chk({name, " idle carry"}, carry, 0);
    chk({name, " idle zero"}, zero, 0);
`ifdef EXEC_EXT_FLAGS_EN
    chk({name, " idle negative"}, negative, 0);
    chk({name, " idle overflow"}, overflow, 0);
`endif
  endtask

  task automatic chk_out(input string name, input exp_t e);
    chk({name, " result"}, result, e.res);
    chk({name, " carry"}, carry, e.c);
    chk({name, " zero"}, zero, e.z);
    chk({name, " out_valid"}, out_valid, 1);
    chk({name, " in_ready"}, in_ready, 0);
`ifdef EXEC_EXT_FLAGS_EN
    chk({name, " negative"}, negative, e.n);
    chk({name, " overflow"}, overflow, e.v);
`endif
  endtask

  // One full transaction: accept, latency, hold under backpressure, handshake
  task automatic do_op(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic [2:0] op, input int hold, input exp_t e);
    int cyc;
    bit seen;
    @(negedge clk);
    operanda = a;
    operandb = b;
    alu_op   = op;
    in_valid = 1'b1;
    chk({name, " accept in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    operanda = 16'($urandom);
    operandb = 16'($urandom);
    alu_op   = 3'($urandom);
    chk({name, " busy in_ready"}, in_ready, 0);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (out_valid) seen = 1'b1;
    end
    chk({name, " latency"}, cyc, NSLICE + 1);
    chk_out(name, e);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk_out({name, " held"}, e);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk_idle(name);
  endtask

  vec_t tbl[13];
  exp_t em;

  initial begin
    tbl[0]  = '{16'h00FF, 16'h0001, OP_ADD,  '{16'h0100, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[1]  = '{16'hFFFF, 16'h0001, OP_ADD,  '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[2]  = '{16'h8001, 16'h0000, OP_SHL,  '{16'h0002, 1'b1, 1'b0, 1'b0, 1'b0}};
    tbl[3]  = '{16'h0001, 16'h0002, OP_SUB,  '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[4]  = '{16'h1234, 16'h1234, OP_CMP,  '{16'h1234, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[5]  = '{16'h0000, 16'hFFFF, OP_PASS, '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[6]  = '{16'hF0F0, 16'h3C3C, OP_AND,  '{16'h3030, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[7]  = '{16'h0F00, 16'h00F0, OP_OR,   '{16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b0}};
    tbl[8]  = '{16'hAAAA, 16'hAAAA, OP_XOR,  '{16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}};
    tbl[9]  = '{16'h0001, 16'h0002, OP_CMP,  '{16'h0001, 1'b0, 1'b0, 1'b1, 1'b0}};
    tbl[10] = '{16'h0005, 16'h0005, OP_SUB,  '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    tbl[11] = '{16'h7FFF, 16'h0001, OP_ADD,  '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1}};
    tbl[12] = '{16'h8000, 16'h0001, OP_SUB,  '{16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1}};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    operanda  = 16'h0000;
    operandb  = 16'h0000;
    alu_op    = OP_PASS;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("reset");

    // Directed table; entry 0 also exercises 5 cycles of backpressure
    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].op,
            (i == 0) ? 5 : 0, tbl[i].e);
    end

    // Reset while BUSY discards the operation
    @(negedge clk);
    operanda = 16'h1111;
    operandb = 16'h0002;
    alu_op   = OP_SUB;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("rstbusy in_ready low", in_ready, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_idle("rstbusy");
    for (int k = 0; k < NSLICE + 3; k++) begin
      @(negedge clk);
      chk("rstbusy no out_valid", out_valid, 0);
    end
    em = '{16'h0007, 1'b0, 1'b0, 1'b0, 1'b0};
    do_op("after_rst add", 16'h0003, 16'h0004, OP_ADD, 0, em);

    // Randomized operations against the reference model
    for (int r = 0; r < 40; r++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic [2:0]  rop;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 3'($urandom_range(0, 7));
      do_op($sformatf("rand%0d op%0d", r, rop), ra, rb, rop,
            int'($urandom_range(0, 2)), model(ra, rb, rop));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
